fetch_unit: RTL and testbench

- Instruction-fetch and next-PC block for the single-cycle LEGv8 datapath.
- Holds the program counter, presents the instruction address, and returns the opcode field to the control decoder.
- Applies the decoder's branch controls (uncond_branch, br_taken, br_reg) to select the next PC.
- Owns the architectural NZVC flag register that the decoder reads to resolve B.cond.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/branch_target.sv | 70 +++++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by the LEGv8 single-cycle datapath blocks.
//
//   Contents:
//     ADDR_W_DEFAULT  default width of the PC and instruction address
//     INSTR_BYTES     size of one instruction in bytes (sequential PC step)
//     OP_*            11-bit opcode patterns of the supported instructions
//     OP_*_MASK       which of those 11 bits are significant (1 = compare)
//     flags_t         architectural NZVC condition flags
//     op_match()      masked opcode comparison helper for the decoder
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 64;
    localparam int INSTR_BYTES    = 4;

    // Opcodes are the top 11 bits of the instruction word. Formats with a
    // shorter opcode (B, BL, CBZ, B.cond, ADDI) carry immediate bits in the
    // remaining positions, so the mask clears them before comparing.
    localparam logic [10:0] OP_ADDI        = 11'b10010001000;
    localparam logic [10:0] OP_ADDI_MASK   = 11'b11111111110;
    localparam logic [10:0] OP_ADDS        = 11'b10101011000;
    localparam logic [10:0] OP_ADDS_MASK   = 11'b11111111111;
    localparam logic [10:0] OP_SUBS        = 11'b11101011000;
    localparam logic [10:0] OP_SUBS_MASK   = 11'b11111111111;
    localparam logic [10:0] OP_B           = 11'b00010100000;
    localparam logic [10:0] OP_B_MASK      = 11'b11111100000;
    localparam logic [10:0] OP_B_COND      = 11'b01010100000;
    localparam logic [10:0] OP_B_COND_MASK = 11'b11111111000;
    localparam logic [10:0] OP_BL          = 11'b10010100000;
    localparam logic [10:0] OP_BL_MASK     = 11'b11111100000;
    localparam logic [10:0] OP_BR          = 11'b11010110000;
    localparam logic [10:0] OP_BR_MASK     = 11'b11111111111;
    localparam logic [10:0] OP_CBZ         = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK    = 11'b11111111000;
    localparam logic [10:0] OP_LDUR        = 11'b11111000010;
    localparam logic [10:0] OP_LDUR_MASK   = 11'b11111111111;
    localparam logic [10:0] OP_STUR        = 11'b11111000000;
    localparam logic [10:0] OP_STUR_MASK   = 11'b11111111111;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry;
    } flags_t;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] pattern,
                                      input logic [10:0] mask);
        return (op & mask) == (pattern & mask);
    endfunction

endpackage

// File: rtl/branch_target.sv
// ---------------------------------------------------------------------------
// branch_target
//   Combinational next-PC selection for the LEGv8 fetch path. Kept as its
//   own block so a later pipelined datapath can move it to another stage.
//
//   Ports:
//     pc             in   ADDR_W  current program counter
//     imem_data      in   32      instruction word fetched from pc
//     uncond_branch  in   1       B/BL form (imm26) when the branch is taken
//     br_taken       in   1       final taken decision from the decoder
//     br_reg         in   1       target comes from reg_target (BR)
//     reg_target     in   ADDR_W  register-file value used by BR
//     next_pc        out  ADDR_W  address of the next instruction
//
//   Selection priority:
//     not taken            -> pc + 4
//     taken, br_reg        -> reg_target with bits [1:0] cleared
//     taken, uncond_branch -> pc + sext(imm26) * 4
//     taken, otherwise     -> pc + sext(imm19) * 4   (CBZ, B.cond)
//   All additions wrap modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module branch_target
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       imem_data,
    input  logic              uncond_branch,
    input  logic              br_taken,
    input  logic              br_reg,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] off26;
    logic [ADDR_W-1:0] off19;
    logic [ADDR_W-1:0] reg_aligned;

    // Offsets are built already shifted by two: the sign bit is replicated
    // into the upper bits and two zero bits are appended at the bottom.
    assign off26 = {{(ADDR_W-28){imem_data[25]}}, imem_data[25:0], 2'b00};
    assign off19 = {{(ADDR_W-21){imem_data[23]}}, imem_data[23:5], 2'b00};

    assign seq_pc = pc + ADDR_W'(INSTR_BYTES);

    // BR targets are forced word-aligned; a misaligned register value
    // never reaches the PC.
    assign reg_aligned = {reg_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        next_pc = seq_pc;
        if (br_taken) begin
            if (br_reg) begin
                next_pc = reg_aligned;
            end else if (uncond_branch) begin
                next_pc = pc + off26;
            end else begin
                next_pc = pc + off19;
            end
        end
    end

    // Opcode bits and the discarded low bits of the register target do not
    // influence the target address.
    logic unused_bits;
    assign unused_bits = ^{imem_data[31:26], reg_target[1:0]};

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch and next-PC block of the single-cycle LEGv8 datapath.
//   Holds the PC, the architectural NZVC flags and a retired-instruction
//   counter; everything else is combinational from pc and imem_data.
//
//   Ports:
//     clk            in   1       rising-edge clock
//     reset          in   1       synchronous, active-high; dominates all
//     stall          in   1       hold pc, flags and retired this cycle
//     imem_addr      out  ADDR_W  instruction address (= pc)
//     imem_data      in   32      instruction word read from imem_addr
//     opcode         out  11      imem_data[31:21] for the control decoder
//     uncond_branch  in   1       decoder UncondBranch
//     br_taken       in   1       decoder final taken decision
//     br_reg         in   1       taken branch uses reg_target (BR)
//     reg_target     in   ADDR_W  register value for BR
//     set_flags      in   1       current instruction writes NZVC
//     alu_*          in   1 each  ALU flags of the current instruction
//     flag_*         out  1 each  registered NZVC
//     pc             out  ADDR_W  current PC
//     link_addr      out  ADDR_W  pc + 4, BL return address
//     retired        out  32      instructions completed since reset,
//                                 saturating at all-ones
//
//   Flow control: stall is the only qualifier. On a rising edge with
//   reset=0 and stall=0 the current instruction completes: pc takes
//   next_pc, retired increments and the flags load if set_flags=1. With
//   stall=1 all three registers hold and the outputs keep reflecting the
//   held pc. Branch controls are sampled on the same edge only, so a taken
//   branch costs no extra cycle.
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [10:0]       opcode,
    input  logic              uncond_branch,
    input  logic              br_taken,
    input  logic              br_reg,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              set_flags,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    output logic              flag_negative,
    output logic              flag_zero,
    output logic              flag_overflow,
    output logic              flag_carry,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic [31:0]       retired
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] next_pc;
    flags_t            flags_q;
    flags_t            alu_flags;
    logic [31:0]       retired_q;
    logic [31:0]       retired_next;

    branch_target #(
        .ADDR_W (ADDR_W)
    ) u_branch_target (
        .pc            (pc_q),
        .imem_data     (imem_data),
        .uncond_branch (uncond_branch),
        .br_taken      (br_taken),
        .br_reg        (br_reg),
        .reg_target    (reg_target),
        .next_pc       (next_pc)
    );

    assign alu_flags = '{negative: alu_negative,
                         zero:     alu_zero,
                         overflow: alu_overflow,
                         carry:    alu_carry};

    // The counter sticks at all-ones rather than wrapping so a long run
    // never reports a misleadingly small count.
    always_comb begin
        retired_next = retired_q;
        if (retired_q != 32'hFFFF_FFFF) begin
            retired_next = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            flags_q   <= '0;
            retired_q <= '0;
        end else if (!stall) begin
            pc_q      <= next_pc;
            retired_q <= retired_next;
            if (set_flags) begin
                flags_q <= alu_flags;
            end
        end
    end

    assign pc            = pc_q;
    assign imem_addr     = pc_q;
    assign link_addr     = pc_q + ADDR_W'(INSTR_BYTES);
    assign opcode        = imem_data[31:21];
    assign retired       = retired_q;
    assign flag_negative = flags_q.negative;
    assign flag_zero     = flags_q.zero;
    assign flag_overflow = flags_q.overflow;
    assign flag_carry    = flags_q.carry;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit: directed scenarios with literal
//   expectations, then randomized traffic checked every cycle against an
//   arithmetic model of the PC, flags and retired counter.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          ADDR_W   = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              stall;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [10:0]       opcode;
    logic              uncond_branch;
    logic              br_taken;
    logic              br_reg;
    logic [ADDR_W-1:0] reg_target;
    logic              set_flags;
    logic              alu_negative, alu_zero, alu_overflow, alu_carry;
    logic              flag_negative, flag_zero, flag_overflow, flag_carry;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_addr;
    logic [31:0]       retired;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .opcode        (opcode),
        .uncond_branch (uncond_branch),
        .br_taken      (br_taken),
        .br_reg        (br_reg),
        .reg_target    (reg_target),
        .set_flags     (set_flags),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry     (alu_carry),
        .flag_negative (flag_negative),
        .flag_zero     (flag_zero),
        .flag_overflow (flag_overflow),
        .flag_carry    (flag_carry),
        .pc            (pc),
        .link_addr     (link_addr),
        .retired       (retired)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural state computed straight from the branch rules.
    logic [63:0] m_pc;
    logic [3:0]  m_flags;
    logic [31:0] m_ret;
    bit          m_valid = 0;
    logic [63:0] exp_q[$];

    always @(posedge clk) begin
        longint signed off;
        if (reset === 1'b1) begin
            m_pc    = RESET_PC;
            m_flags = 4'b0000;
            m_ret   = 32'd0;
            m_valid = 1;
        end else if (m_valid && stall === 1'b0) begin
            if (!br_taken) begin
                m_pc = m_pc + 64'd4;
            end else if (br_reg) begin
                m_pc = reg_target & ~64'd3;
            end else if (uncond_branch) begin
                off  = longint'($signed(imem_data[25:0]));
                m_pc = m_pc + 64'(off * 4);
            end else begin
                off  = longint'($signed(imem_data[23:5]));
                m_pc = m_pc + 64'(off * 4);
            end
            if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
            if (set_flags) m_flags = {alu_negative, alu_zero, alu_overflow, alu_carry};
        end
        if (m_valid) exp_q.push_back(m_pc);
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        logic [63:0] exp_pc;
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_queue_empty", 64'd0, 64'd1);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("sb_pc",        pc,        exp_pc);
                chk("sb_imem_addr", imem_addr, exp_pc);
                chk("sb_link_addr", link_addr, exp_pc + 64'd4);
                chk("sb_opcode",    64'(opcode), 64'(imem_data >> 21));
                chk("sb_flags", 64'({flag_negative, flag_zero, flag_overflow, flag_carry}),
                    64'(m_flags));
                chk("sb_retired",   64'(retired), 64'(m_ret));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic rst, input logic stl,
                              input logic [31:0] instr,
                              input logic ub, input logic bt, input logic brg,
                              input logic [63:0] rt,
                              input logic sf, input logic [3:0] nzvc);
        reset         = rst;
        stall         = stl;
        imem_data     = instr;
        uncond_branch = ub;
        br_taken      = bt;
        br_reg        = brg;
        reg_target    = rt;
        set_flags     = sf;
        {alu_negative, alu_zero, alu_overflow, alu_carry} = nzvc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) begin
            set_inputs(0, 0, 32'h8B00_0000, 0, 0, 0, 64'd0, 0, 4'b0000);
            tick();
        end
    endtask

    function automatic logic [3:0] cur_flags();
        return {flag_negative, flag_zero, flag_overflow, flag_carry};
    endfunction

    // ---------------- stimulus ----------------
    localparam logic [31:0] INSTR_BL  = {6'b100101, 26'h3FF_FFFE};
    localparam logic [31:0] INSTR_CBZ = {8'hB4, 19'd3, 5'd0};
    localparam logic [31:0] INSTR_BR  = 32'hD61F_03C0;
    localparam logic [31:0] INSTR_SUB = 32'hEB01_0000;

    initial begin
        set_inputs(1, 0, 32'd0, 0, 0, 0, 64'd0, 0, 4'b0000);

        // reset
        tick();
        tick();
        chk("reset_pc",      pc, 64'h0);
        chk("reset_flags",   64'(cur_flags()), 64'h0);
        chk("reset_retired", 64'(retired), 64'h0);
        chk("reset_link",    link_addr, 64'h4);

        // three free-running cycles
        plain(3);
        chk("free_pc",      pc, 64'hC);
        chk("free_retired", 64'(retired), 64'd3);
        chk("free_link",    link_addr, 64'h10);
        chk("free_flags",   64'(cur_flags()), 64'h0);

        // BL at 0x10, imm26 = -2 -> 0x8; link_addr during the BL cycle
        plain(1);
        set_inputs(0, 0, INSTR_BL, 1, 1, 0, 64'd0, 0, 4'b0000);
        #1;
        chk("bl_link",   link_addr, 64'h14);
        chk("bl_opcode", 64'(opcode), 64'h4BF);
        tick();
        chk("bl_target", pc, 64'h8);

        // CBZ at 0x20, imm19 = 3, taken -> 0x2C
        plain(6);
        chk("cbz_setup_pc", pc, 64'h20);
        set_inputs(0, 0, INSTR_CBZ, 0, 1, 0, 64'd0, 0, 4'b0000);
        tick();
        chk("cbz_taken", pc, 64'h2C);

        // BR to 0x103 -> 0x100, then BR back to 0x20
        set_inputs(0, 0, INSTR_BR, 0, 1, 1, 64'h103, 0, 4'b0000);
        tick();
        chk("br_align", pc, 64'h100);
        set_inputs(0, 0, INSTR_BR, 0, 1, 1, 64'h23, 0, 4'b0000);
        tick();
        chk("br_back", pc, 64'h20);

        // CBZ at 0x20 not taken -> 0x24
        set_inputs(0, 0, INSTR_CBZ, 0, 0, 0, 64'd0, 0, 4'b0000);
        tick();
        chk("cbz_not_taken", pc, 64'h24);
        chk("retired_15",    64'(retired), 64'd15);

        // SUBS with NZVC=1001 under stall, then released
        set_inputs(0, 1, INSTR_SUB, 0, 0, 0, 64'd0, 1, 4'b1001);
        tick();
        chk("stall_pc",      pc, 64'h24);
        chk("stall_flags",   64'(cur_flags()), 64'h0);
        chk("stall_retired", 64'(retired), 64'd15);
        set_inputs(0, 0, INSTR_SUB, 0, 0, 0, 64'd0, 1, 4'b1001);
        tick();
        chk("subs_flags",   64'(cur_flags()), 64'h9);
        chk("subs_pc",      pc, 64'h28);
        chk("subs_retired", 64'(retired), 64'd16);

        // PC wrap at all-ones-minus-3
        set_inputs(0, 0, INSTR_BR, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b0000);
        tick();
        chk("wrap_setup", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_link",  link_addr, 64'h0);
        plain(1);
        chk("wrap_pc", pc, 64'h0);

        // reset together with a taken branch to 0x40 and set_flags
        set_inputs(1, 0, INSTR_BR, 0, 1, 1, 64'h40, 1, 4'b1111);
        tick();
        chk("rst_dom_pc",      pc, 64'h0);
        chk("rst_dom_flags",   64'(cur_flags()), 64'h0);
        chk("rst_dom_retired", 64'(retired), 64'h0);

        // randomized traffic, checked by the per-cycle scoreboard
        for (int i = 0; i < 600; i++) begin
            logic [63:0] rt;
            rt = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rt = 64'hFFFF_FFFF_FFFF_FFFF;
            set_inputs($urandom_range(0, 49) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom,
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       $urandom_range(0, 2) == 0,
                       rt,
                       1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)));
            tick();
        end

        plain(2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
